pcie_sipo_aligner: RTL and testbench

Receive-side serial-to-parallel converter for the PCIe PHY lane. It shifts in the MSB-first serial bitstream produced by the lane serializer and recovers symbol boundaries by detecting K28.5 comma patterns. Once aligned, it emits one DATA_WIDTH-bit symbol per DATA_WIDTH enabled bits to the 8b/10b decoder. It sits between the lane serial input and the decoder, mirroring the transmit-side serializer.

---
 rtl/pcie_phy_pkg.sv | 17 +
 rtl/pcie_comma_detect.sv | 22 ++
 rtl/pcie_sipo_aligner.sv | 151 +++++++++++++++
 tb/tb_pcie_sipo_aligner.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions.
//   - align_state_e : receive symbol-alignment states (UNLOCKED, ALIGNED, LOCKED)
//   - K28_5_P/N     : K28.5 comma, RD- and RD+ forms, MSB first. These are
//                     shared by the transmit serializer, the aligner and the
//                     decoder.
package pcie_phy_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGNED  = 2'd1,
    LOCKED   = 2'd2
  } align_state_e;

  localparam logic [9:0] K28_5_P = 10'b0011111010;
  localparam logic [9:0] K28_5_N = 10'b1100000101;

endpackage

// File: rtl/pcie_comma_detect.sv
// Combinational comma detector.
// It compares a candidate symbol window against both running-disparity forms
// of the comma. A match is reported only once the window holds real received
// bits. This block is also used by the elastic buffer.
//   i_sr_next   : candidate window, first-received bit in the MSB
//   i_fill_done : window is fully populated with received bits
//   o_hit       : window equals COMMA_P or COMMA_N
module pcie_comma_detect
  import pcie_phy_pkg::*;
#(
  parameter int                    DATA_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] COMMA_P    = K28_5_P,
  parameter logic [DATA_WIDTH-1:0] COMMA_N    = K28_5_N
) (
  input  logic [DATA_WIDTH-1:0] i_sr_next,
  input  logic                  i_fill_done,
  output logic                  o_hit
);

  assign o_hit = i_fill_done && ((i_sr_next == COMMA_P) || (i_sr_next == COMMA_N));

endmodule

// File: rtl/pcie_sipo_aligner.sv
// Receive-side serial-to-parallel converter with comma-based symbol alignment.
// It shifts in an MSB-first serial stream and finds symbol boundaries from
// K28.5 commas. Once aligned, it emits one DATA_WIDTH-bit symbol per
// DATA_WIDTH enabled bits.
//   clk          : lane bit clock
//   reset_n      : asynchronous active-low reset
//   enable       : bit strobe; data_in is sampled only when high
//   data_in      : serial bit
//   symbol_out   : recovered symbol, first-received bit in the MSB (held between pulses)
//   symbol_valid : one-cycle pulse when symbol_out is new
//   is_comma     : qualifies symbol_valid; the symbol is a comma
//   locked       : high while in LOCKED
module pcie_sipo_aligner
  import pcie_phy_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 10,
  parameter logic [DATA_WIDTH-1:0] COMMA_P      = K28_5_P,
  parameter logic [DATA_WIDTH-1:0] COMMA_N      = K28_5_N,
  parameter int                    LOCK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  data_in,
  output logic [DATA_WIDTH-1:0] symbol_out,
  output logic                  symbol_valid,
  output logic                  is_comma,
  output logic                  locked
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam int               TO_W     = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);

  align_state_e          r_state;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]      r_fill_cnt;
  logic [TO_W-1:0]       r_to_cnt;
  logic [DATA_WIDTH-1:0] r_symbol;
  logic                  r_valid;
  logic                  r_is_comma;

  align_state_e          w_state_next;
  logic [DATA_WIDTH-1:0] w_sr_next;
  logic                  w_fill_done;
  logic                  w_comma_hit;
  logic                  w_last_bit;
  logic                  w_emit;
  logic [CNT_W-1:0]      w_bit_cnt_next;
  logic [TO_W-1:0]       w_to_cnt_next;

  assign w_sr_next = {r_sr[DATA_WIDTH-2:0], data_in};
  // The fill counter saturates at W-1. The bit being sampled now completes
  // the first fully populated window.
  assign w_fill_done = (r_fill_cnt == LAST_BIT);
  assign w_last_bit  = (r_bit_cnt == LAST_BIT);

  pcie_comma_detect #(
    .DATA_WIDTH (DATA_WIDTH),
    .COMMA_P    (COMMA_P),
    .COMMA_N    (COMMA_N)
  ) u_comma_detect (
    .i_sr_next   (w_sr_next),
    .i_fill_done (w_fill_done),
    .o_hit       (w_comma_hit)
  );

  always_comb begin
    w_state_next  = r_state;
    w_emit        = 1'b0;
    w_to_cnt_next = r_to_cnt;
    // Any comma re-phases the boundary, even an aligned one, where the
    // counter wraps to 0 anyway.
    if (w_comma_hit || w_last_bit) w_bit_cnt_next = '0;
    else                           w_bit_cnt_next = r_bit_cnt + CNT_W'(1);

    case (r_state)
      UNLOCKED: begin
        if (w_comma_hit) begin
          w_state_next  = ALIGNED;
          w_emit        = 1'b1;
          w_to_cnt_next = '0;
        end
      end
      ALIGNED: begin
        // A comma wins over a timeout expiry on the same boundary.
        if (w_comma_hit) begin
          w_emit        = 1'b1;
          w_to_cnt_next = '0;
          if (w_last_bit) w_state_next = LOCKED;
        end else if (w_last_bit) begin
          w_emit = 1'b1;
          if (r_to_cnt == TO_LAST) begin
            w_state_next  = UNLOCKED;
            w_to_cnt_next = '0;
          end else begin
            w_to_cnt_next = r_to_cnt + TO_W'(1);
          end
        end
      end
      LOCKED: begin
        if (w_comma_hit && !w_last_bit) begin
          w_state_next  = ALIGNED;
          w_emit        = 1'b1;
          w_to_cnt_next = '0;
        end else if (w_last_bit) begin
          w_emit = 1'b1;
        end
      end
      default: w_state_next = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_state <= UNLOCKED;
    else if (enable) r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_fill_cnt <= '0;
      r_to_cnt   <= '0;
      r_symbol   <= '0;
      r_valid    <= 1'b0;
      r_is_comma <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (enable) begin
        r_sr      <= w_sr_next;
        r_bit_cnt <= w_bit_cnt_next;
        r_to_cnt  <= w_to_cnt_next;
        if (!w_fill_done) r_fill_cnt <= r_fill_cnt + CNT_W'(1);
        if (w_emit) begin
          r_symbol   <= w_sr_next;
          r_valid    <= 1'b1;
          r_is_comma <= w_comma_hit;
        end
      end
    end
  end

  assign symbol_out   = r_symbol;
  assign symbol_valid = r_valid;
  assign is_comma     = r_is_comma;
  assign locked       = (r_state == LOCKED);

endmodule

// File: tb/tb_pcie_sipo_aligner.sv
// Directed testbench for pcie_sipo_aligner. It drives MSB-first serial
// symbols and checks the emitted symbols, comma flags, lock state and
// pulse timing against hand-derived values.
module tb_pcie_sipo_aligner;

  localparam logic [9:0] SYM_P = 10'h0FA;  // 0011111010
  localparam logic [9:0] SYM_N = 10'h305;  // 1100000101
  localparam logic [9:0] SYM_A = 10'h2AA;  // 1010101010
  localparam logic [9:0] SYM_5 = 10'h155;  // 0101010101

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       data_in;
  logic [9:0] symbol_out;
  logic       symbol_valid;
  logic       is_comma;
  logic       locked;

  int tests_run;
  int tests_failed;

  // Monitor state, cleared by clear_mon.
  int         cyc;
  int         n_valid;
  int         first_cyc;
  logic [9:0] last_sym;
  logic       last_comma;

  pcie_sipo_aligner dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .data_in      (data_in),
    .symbol_out   (symbol_out),
    .symbol_valid (symbol_valid),
    .is_comma     (is_comma),
    .locked       (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_mon();
    cyc        = 0;
    n_valid    = 0;
    first_cyc  = 0;
    last_sym   = '0;
    last_comma = 1'b0;
  endtask

  task automatic shift_bit(input logic b, input logic en);
    @(negedge clk);
    enable  = en;
    data_in = en ? b : 1'bz;
    @(posedge clk);
    #1;
    cyc++;
    if (symbol_valid === 1'b1) begin
      n_valid++;
      last_sym   = symbol_out;
      last_comma = is_comma;
      if (first_cyc == 0) first_cyc = cyc;
    end
  endtask

  task automatic shift_bits(input logic [9:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i], 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) shift_bit(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    enable  = 1'b0;
    data_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_mon();
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    enable  = 1'b0;
    data_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({symbol_out, symbol_valid, is_comma, locked} !== 13'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got sym=%h v=%b c=%b l=%b required all 0",
               symbol_out, symbol_valid, is_comma, locked);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_lock();
    do_reset();
    shift_bits(SYM_P, 10);
    tests_run++;
    if (n_valid !== 1 || first_cyc !== 10 || last_sym !== SYM_P || last_comma !== 1'b1) begin
      tests_failed++;
      $display("FAIL lock_first_comma: got n=%0d cyc=%0d sym=%h c=%b required n=1 cyc=10 sym=%h c=1",
               n_valid, first_cyc, last_sym, last_comma, SYM_P);
    end
    tests_run++;
    if (locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_aligned_not_locked: got locked=%b required 0", locked);
    end
    clear_mon();
    shift_bits(SYM_A, 10);
    tests_run++;
    if (n_valid !== 1 || first_cyc !== 10 || last_sym !== SYM_A || last_comma !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_data_sym: got n=%0d cyc=%0d sym=%h c=%b required n=1 cyc=10 sym=%h c=0",
               n_valid, first_cyc, last_sym, last_comma, SYM_A);
    end
    clear_mon();
    shift_bits(SYM_N, 10);
    tests_run++;
    if (n_valid !== 1 || last_sym !== SYM_N || last_comma !== 1'b1 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL lock_confirm: got n=%0d sym=%h c=%b locked=%b required n=1 sym=%h c=1 locked=1",
               n_valid, last_sym, last_comma, locked, SYM_N);
    end
  endtask

  task automatic test_no_false_comma();
    do_reset();
    shift_bits(10'b0011111010, 8);
    tests_run++;
    if (n_valid !== 0 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_false_comma: got n=%0d locked=%b required n=0 locked=0", n_valid, locked);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    shift_bits(SYM_P, 10);
    shift_bits(SYM_N, 10);
    clear_mon();
    shift_bits(10'b101, 3);
    shift_bits(SYM_P, 10);
    // The old phase still closes a data symbol 101_0011111 before the comma lands.
    tests_run++;
    if (n_valid !== 2 || first_cyc !== 10 || last_sym !== SYM_P || last_comma !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned_comma: got n=%0d cyc=%0d sym=%h c=%b required n=2 cyc=10 sym=%h c=1",
               n_valid, first_cyc, last_sym, last_comma, SYM_P);
    end
    tests_run++;
    if (locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL misaligned_drop_lock: got locked=%b required 0", locked);
    end
    clear_mon();
    shift_bits(SYM_A, 10);
    tests_run++;
    if (n_valid !== 1 || first_cyc !== 10 || last_sym !== SYM_A) begin
      tests_failed++;
      $display("FAIL misaligned_rephase: got n=%0d cyc=%0d sym=%h required n=1 cyc=10 sym=%h",
               n_valid, first_cyc, last_sym, SYM_A);
    end
    clear_mon();
    shift_bits(SYM_P, 10);
    tests_run++;
    if (locked !== 1'b1 || last_comma !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned_relock: got locked=%b c=%b required locked=1 c=1", locked, last_comma);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    shift_bits(SYM_P, 10);
    clear_mon();
    for (int s = 0; s < 16; s++) shift_bits(SYM_5, 10);
    tests_run++;
    if (n_valid !== 16 || last_sym !== SYM_5 || last_comma !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pulses: got n=%0d sym=%h c=%b required n=16 sym=%h c=0",
               n_valid, last_sym, last_comma, SYM_5);
    end
    clear_mon();
    shift_bits(SYM_5, 10);
    shift_bits(SYM_5, 10);
    tests_run++;
    if (n_valid !== 0 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_unlocked: got n=%0d locked=%b required n=0 locked=0", n_valid, locked);
    end
  endtask

  task automatic test_comma_priority();
    do_reset();
    shift_bits(SYM_P, 10);
    for (int s = 0; s < 15; s++) shift_bits(SYM_5, 10);
    clear_mon();
    shift_bits(SYM_P, 10);
    tests_run++;
    if (n_valid !== 1 || last_comma !== 1'b1 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL comma_priority: got n=%0d c=%b locked=%b required n=1 c=1 locked=1",
               n_valid, last_comma, locked);
    end
  endtask

  task automatic test_enable_gap();
    do_reset();
    shift_bits(SYM_P, 10);
    shift_bits(SYM_N, 10);
    clear_mon();
    shift_bits(SYM_A >> 6, 4);
    idle(5);
    shift_bits(SYM_A & 10'h03F, 6);
    tests_run++;
    if (n_valid !== 1 || first_cyc !== 15 || last_sym !== SYM_A) begin
      tests_failed++;
      $display("FAIL enable_gap: got n=%0d cyc=%0d sym=%h required n=1 cyc=15 sym=%h",
               n_valid, first_cyc, last_sym, SYM_A);
    end
    tests_run++;
    if (locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL enable_gap_lock: got locked=%b required 1", locked);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    shift_bits(SYM_P, 10);
    shift_bits(SYM_N, 10);
    shift_bits(10'b1010, 4);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({symbol_out, symbol_valid, is_comma, locked} !== 13'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_async: got sym=%h v=%b c=%b l=%b required all 0",
               symbol_out, symbol_valid, is_comma, locked);
    end
    enable  = 1'b0;
    data_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_mon();
    shift_bits(10'b0011111010, 8);
    tests_run++;
    if (n_valid !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset_fill: got n=%0d required 0", n_valid);
    end
    shift_bits(SYM_P, 10);
    tests_run++;
    if (n_valid !== 1 || first_cyc !== 18 || last_sym !== SYM_P || last_comma !== 1'b1 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_realign: got n=%0d cyc=%0d sym=%h c=%b l=%b required n=1 cyc=18 sym=%h c=1 l=0",
               n_valid, first_cyc, last_sym, last_comma, locked, SYM_P);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b1;
    enable       = 1'b0;
    data_in      = 1'b0;
    clear_mon();
    test_reset();
    test_lock();
    test_no_false_comma();
    test_misaligned();
    test_timeout();
    test_comma_priority();
    test_enable_gap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
